// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - controller/hopper handshake bundle for the change dispenser
interface change_dispenser_if #(
    parameter int CREDIT_W = 3
);
    logic                start;
    logic [CREDIT_W-1:0] credit;
    logic                hop2_empty;
    logic                hop1_empty;
    logic                hop_ack;
    logic                drop2;
    logic                drop1;
    logic                busy;
    logic                done;
    logic                fault;
    logic [CREDIT_W-1:0] remaining;

    modport master (
        output start, credit, hop2_empty, hop1_empty, hop_ack,
        input  drop2, drop1, busy, done, fault, remaining
    );

    modport slave (
        input  start, credit, hop2_empty, hop1_empty, hop_ack,
        output drop2, drop1, busy, done, fault, remaining
    );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy two-hopper coin payout FSM with per-handshake stall timeout
module change_dispenser #(
    parameter int CREDIT_W = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                 Clock,
    input  logic                 Reset,
    change_dispenser_if.slave    bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_REQ2    = 3'd2;
    localparam logic [2:0] S_REQ1    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    // Last count value at which the exit condition is still checked before faulting.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [CREDIT_W-1:0] remaining;

    // Payout sequencing; the wait counter restarts on every REQ/RELEASE entry and an ack beats a same-edge timeout.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        remaining <= bus.credit;
                        state     <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    cnt <= '0;
                    if (remaining == '0)
                        state <= S_DONE;
                    else if (remaining >= CREDIT_W'(2) && !bus.hop2_empty)
                        state <= S_REQ2;
                    else if (!bus.hop1_empty)
                        state <= S_REQ1;
                    else
                        state <= S_FAULT;
                end
                S_REQ2, S_REQ1: begin
                    if (bus.hop_ack) begin
                        remaining <= remaining - ((state == S_REQ2) ? CREDIT_W'(2) : CREDIT_W'(1));
                        cnt       <= '0;
                        state     <= S_RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!bus.hop_ack)
                        state <= S_SELECT;
                    else if (cnt == CNT_LAST)
                        state <= S_FAULT;
                    else
                        cnt <= cnt + 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs straight from the state register.
    always_comb begin
        bus.drop2     = (state == S_REQ2);
        bus.drop1     = (state == S_REQ1);
        bus.busy      = (state == S_SELECT) || (state == S_REQ2) || (state == S_REQ1) ||
                        (state == S_RELEASE) || (state == S_DONE);
        bus.done      = (state == S_DONE);
        bus.fault     = (state == S_FAULT);
        bus.remaining = remaining;
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - table-driven bench for change_dispenser
module tb_change_dispenser;
    logic Clock;
    logic Reset;

    change_dispenser_if #(.CREDIT_W(3)) bus ();

    change_dispenser #(.CREDIT_W(3), .TIMEOUT(15)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0] credit;
        logic       h2e;
        logic       h1e;
        int         delay;
        int         n2;
        int         n1;
        logic       flt;
        int         rem_end;
    } vec_t;

    vec_t vecs[9];
    int   compared;
    int   mismatched;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.start   = 1'b0;
        bus.hop_ack = 1'b0;
        Reset       = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic run_payout(input vec_t v, input int idx);
        int   n2, n1, ndone, wait_cnt, coin, exp_rem;
        logic pd2, pd1;
        bit   finished;
        n2 = 0; n1 = 0; ndone = 0; wait_cnt = 0; coin = 0;
        pd2 = 1'b0; pd1 = 1'b0; finished = 1'b0;
        bus.hop2_empty = v.h2e;
        bus.hop1_empty = v.h1e;
        bus.hop_ack    = 1'b0;
        bus.credit     = v.credit;
        bus.start      = 1'b1;
        @(negedge Clock);
        bus.start  = 1'b0;
        bus.credit = 3'd0;
        exp_rem    = int'(v.credit);
        chk($sformatf("v%0d busy_after_start", idx), int'(bus.busy), 1);
        chk($sformatf("v%0d rem_latched", idx), int'(bus.remaining), exp_rem);
        chk($sformatf("v%0d no_drop_in_select", idx), int'(bus.drop2 | bus.drop1), 0);
        for (int c = 0; c < 400 && !finished; c++) begin
            @(negedge Clock);
            if (bus.drop2 && bus.drop1) chk($sformatf("v%0d both_drops", idx), 1, 0);
            if (bus.done) ndone++;
            if (bus.drop2 && !pd2) begin n2++; coin = 2; wait_cnt = 0; end
            if (bus.drop1 && !pd1) begin n1++; coin = 1; wait_cnt = 0; end
            if ((pd2 && !bus.drop2) || (pd1 && !bus.drop1)) begin
                exp_rem -= coin;
                chk($sformatf("v%0d rem_after_coin", idx), int'(bus.remaining), exp_rem);
                bus.hop_ack = 1'b0;
            end
            if ((bus.drop2 || bus.drop1) && !bus.hop_ack) begin
                if (wait_cnt >= v.delay) bus.hop_ack = 1'b1;
                else wait_cnt++;
            end
            pd2 = bus.drop2;
            pd1 = bus.drop1;
            if (bus.fault) finished = 1'b1;
            else if (ndone > 0 && !bus.done) finished = 1'b1;
        end
        bus.hop_ack = 1'b0;
        if (!finished) chk($sformatf("v%0d completion_within_budget", idx), 0, 1);
        chk($sformatf("v%0d n_drop2", idx), n2, v.n2);
        chk($sformatf("v%0d n_drop1", idx), n1, v.n1);
        chk($sformatf("v%0d fault", idx), int'(bus.fault), int'(v.flt));
        chk($sformatf("v%0d rem_end", idx), int'(bus.remaining), v.rem_end);
        chk($sformatf("v%0d done_pulses", idx), ndone, v.flt ? 0 : 1);
        chk($sformatf("v%0d busy_end", idx), int'(bus.busy), 0);
        chk($sformatf("v%0d drops_end", idx), int'(bus.drop2 | bus.drop1), 0);
    endtask

    initial begin
        int   k;
        bit   seen;
        vec_t v2;
        compared   = 0;
        mismatched = 0;
        Reset          = 1'b1;
        bus.start      = 1'b0;
        bus.credit     = 3'd0;
        bus.hop2_empty = 1'b0;
        bus.hop1_empty = 1'b0;
        bus.hop_ack    = 1'b0;

        vecs[0] = '{3'd5, 1'b0, 1'b0, 2, 2, 1, 1'b0, 0};
        vecs[1] = '{3'd3, 1'b1, 1'b0, 1, 0, 3, 1'b0, 0};
        vecs[2] = '{3'd0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0};
        vecs[3] = '{3'd1, 1'b0, 1'b1, 0, 0, 0, 1'b1, 1};
        vecs[4] = '{3'd7, 1'b0, 1'b0, 0, 3, 1, 1'b0, 0};
        vecs[5] = '{3'd6, 1'b0, 1'b1, 3, 3, 0, 1'b0, 0};
        vecs[6] = '{3'd3, 1'b0, 1'b1, 1, 1, 0, 1'b1, 1};
        vecs[7] = '{3'd2, 1'b1, 1'b0, 0, 0, 2, 1'b0, 0};
        vecs[8] = '{3'd4, 1'b1, 1'b1, 0, 0, 0, 1'b1, 4};

        // Reset state
        @(negedge Clock);
        chk("reset_drop2", int'(bus.drop2), 0);
        chk("reset_drop1", int'(bus.drop1), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_fault", int'(bus.fault), 0);
        chk("reset_remaining", int'(bus.remaining), 0);
        Reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_reset();
            run_payout(vecs[i], i);
        end

        // Stalled hopper: drop2 held for exactly TIMEOUT cycles, then sticky fault
        do_reset();
        bus.hop2_empty = 1'b0;
        bus.hop1_empty = 1'b0;
        bus.credit     = 3'd4;
        bus.start      = 1'b1;
        @(negedge Clock);
        bus.start = 1'b0;
        k = 0;
        for (int c = 0; c < 60 && !bus.fault; c++) begin
            @(negedge Clock);
            if (bus.drop2) k++;
        end
        chk("to_drop2_cycles", k, 15);
        chk("to_fault", int'(bus.fault), 1);
        chk("to_drop2_low", int'(bus.drop2), 0);
        chk("to_remaining", int'(bus.remaining), 4);
        chk("to_busy", int'(bus.busy), 0);
        bus.credit = 3'd2;
        bus.start  = 1'b1;
        repeat (3) @(negedge Clock);
        bus.start = 1'b0;
        chk("to_start_ignored_busy", int'(bus.busy), 0);
        chk("to_start_ignored_rem", int'(bus.remaining), 4);
        chk("to_fault_sticky", int'(bus.fault), 1);

        // Ack arriving on the same edge as the timeout wins
        do_reset();
        bus.credit = 3'd2;
        bus.start  = 1'b1;
        @(negedge Clock);
        bus.start = 1'b0;
        @(negedge Clock);
        chk("race_drop2_up", int'(bus.drop2), 1);
        k = 1;
        while (k < 15) begin
            @(negedge Clock);
            k++;
        end
        chk("race_drop2_still", int'(bus.drop2), 1);
        bus.hop_ack = 1'b1;
        @(negedge Clock);
        chk("race_no_fault", int'(bus.fault), 0);
        chk("race_drop2_low", int'(bus.drop2), 0);
        chk("race_remaining", int'(bus.remaining), 0);
        bus.hop_ack = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge Clock);
            if (bus.done) seen = 1'b1;
        end
        chk("race_done", int'(seen), 1);

        // Async reset mid-REQ2, then a clean payout with no extra reset
        do_reset();
        bus.credit = 3'd6;
        bus.start  = 1'b1;
        @(negedge Clock);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge Clock);
            if (bus.drop2) seen = 1'b1;
        end
        chk("mid_req2_reached", int'(seen), 1);
        #2 Reset = 1'b1;
        #1;
        chk("mid_reset_drop2", int'(bus.drop2), 0);
        chk("mid_reset_busy", int'(bus.busy), 0);
        chk("mid_reset_remaining", int'(bus.remaining), 0);
        @(negedge Clock);
        Reset = 1'b0;
        v2 = '{3'd2, 1'b0, 1'b0, 1, 1, 0, 1'b0, 0};
        run_payout(v2, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
